// File: rtl/sram_rd_slv_pkg.sv
// sram_rd_slv_pkg: shared AXI response codes, bus widths, FSM states and LFSR seed
package sram_rd_slv_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [1:0]            axi_resp_t;

    localparam axi_resp_t OKAY   = 2'b00;
    localparam axi_resp_t SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/sram_rd_slv_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), steps only when enabled
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic [7:0] state_o
);

    // Shift left, feedback from taps 8,6,5,4; a nonzero seed never reaches zero
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)
            state_o <= SEED;
        else if (en_i)
            state_o <= {state_o[6:0], state_o[7] ^ state_o[5] ^ state_o[4] ^ state_o[3]};

endmodule

// File: rtl/sram_rd_slv.sv
// sram_rd_slv: AXI4-Lite read responder backed by a word SRAM with programmable latency
module sram_rd_slv
    import sram_rd_slv_pkg::*;
#(
    parameter int                ADDR_W     = AXI_ADDR_W,
    parameter int                DATA_W     = AXI_DATA_W,
    parameter int                DEPTH      = 4096,
    parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
    parameter int                LAT        = 1,
    parameter int                RAND_DELAY = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     slv_ar_valid_i,
    input  logic [ADDR_W-1:0]        slv_ar_addr_i,
    output logic                     slv_ar_ready_o,
    output logic                     slv_r_valid_o,
    output logic [DATA_W-1:0]        slv_r_data_o,
    output logic [1:0]               slv_r_resp_o,
    input  logic                     slv_r_ready_i,
    input  logic                     ld_en_i,
    input  logic [$clog2(DEPTH)-1:0] ld_idx_i,
    input  logic [DATA_W-1:0]        ld_data_i
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [4:0]        cnt;
    logic [IDX_W-1:0]  idx;
    logic              err;
    logic [7:0]        lfsr;
    logic              ar_hs;
    logic [ADDR_W-1:0] off;
    logic              addr_err;
    logic [IDX_W-1:0]  ar_idx;
    logic [4:0]        lat_sel;
    logic [DATA_W-1:0] rd_word;

    assign ar_hs    = slv_ar_valid_i & slv_ar_ready_o;
    assign off      = slv_ar_addr_i - BASE;
    assign addr_err = (slv_ar_addr_i < BASE) | (off >= ADDR_W'(4 * DEPTH)) | (|slv_ar_addr_i[1:0]);
    assign ar_idx   = off[IDX_W+1:2];
    assign lat_sel  = 5'(LAT) + ((RAND_DELAY != 0) ? 5'(lfsr & 8'h07) : 5'd0);
    // A backdoor write landing on the capture edge wins over the stored word
    assign rd_word  = (ld_en_i && ld_idx_i == idx) ? ld_data_i : mem[idx];

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (ar_hs),
        .state_o (lfsr)
    );

    // Backdoor loader; array contents survive reset
    always_ff @(posedge clk_i)
        if (ld_en_i)
            mem[ld_idx_i] <= ld_data_i;

    // Request/response FSM: accept one AR, count down latency, hold R until accepted
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state          <= IDLE;
            slv_ar_ready_o <= 1'b0;
            slv_r_valid_o  <= 1'b0;
            slv_r_data_o   <= '0;
            slv_r_resp_o   <= OKAY;
            cnt            <= '0;
            idx            <= '0;
            err            <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (ar_hs) begin
                        slv_ar_ready_o <= 1'b0;
                        idx            <= ar_idx;
                        err            <= addr_err;
                        cnt            <= lat_sel;
                        state          <= WAIT;
                    end else begin
                        slv_ar_ready_o <= 1'b1;
                    end
                WAIT:
                    if (cnt == 5'd0) begin
                        slv_r_valid_o <= 1'b1;
                        slv_r_data_o  <= err ? '0 : rd_word;
                        slv_r_resp_o  <= err ? SLVERR : OKAY;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                RESP:
                    if (slv_r_ready_i) begin
                        slv_r_valid_o  <= 1'b0;
                        slv_ar_ready_o <= 1'b1;
                        state          <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end

endmodule
